proc_trace_buf: RTL and testbench

PROC_TRACE_BUF -- requirements
Module: proc_trace_buf

---
 rtl/proc_trace_buf.sv | 66 ++++++
 tb/tb_proc_trace_buf.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/proc_trace_buf.sv
// proc_trace_buf: retired-instruction trace FIFO with retire/drop counters and sticky overflow
module proc_trace_buf #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     trace_val,
    input  logic [31:0]              trace_addr,
    input  logic [31:0]              trace_inst,
    input  logic [31:0]              trace_data,
    output logic                     out_val,
    input  logic                     out_rdy,
    output logic [31:0]              out_addr,
    output logic [31:0]              out_inst,
    output logic [31:0]              out_data,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [31:0]              retire_count,
    output logic [31:0]              drop_count,
    output logic                     overflow
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr, rd_ptr;
    logic [31:0] mem_addr [DEPTH];
    logic [31:0] mem_inst [DEPTH];
    logic [31:0] mem_data [DEPTH];
    logic        full, pop, push, drop;

    assign occupancy = wr_ptr - rd_ptr;
    assign full      = occupancy == (AW+1)'(DEPTH);
    assign out_val   = occupancy != '0;
    assign pop       = out_val & out_rdy;
    // a full FIFO still accepts when the head leaves on the same edge
    assign push      = trace_val & (~full | pop);
    assign drop      = trace_val & full & ~pop;
    assign out_addr  = mem_addr[rd_ptr[AW-1:0]];
    assign out_inst  = mem_inst[rd_ptr[AW-1:0]];
    assign out_data  = mem_data[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            retire_count <= '0;
            drop_count   <= '0;
            overflow     <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (trace_val) retire_count <= retire_count + 32'd1;
            if (drop) begin
                drop_count <= drop_count + 32'd1;
                overflow   <= 1'b1;
            end
        end
    end

    // storage is left uncleared; the pointers alone define validity
    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr[AW-1:0]] <= trace_addr;
            mem_inst[wr_ptr[AW-1:0]] <= trace_inst;
            mem_data[wr_ptr[AW-1:0]] <= trace_data;
        end
    end
endmodule

// File: tb/tb_proc_trace_buf.sv
// tb_proc_trace_buf: randomized + directed scoreboard bench for proc_trace_buf
module tb_proc_trace_buf;
    localparam int DEPTH = 8;

    typedef struct {
        logic [31:0] a;
        logic [31:0] i;
        logic [31:0] d;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        trace_val = 1'b0;
    logic [31:0] trace_addr = '0;
    logic [31:0] trace_inst = '0;
    logic [31:0] trace_data = '0;
    logic        out_rdy = 1'b0;
    logic        out_val;
    logic [31:0] out_addr, out_inst, out_data;
    logic [$clog2(DEPTH):0] occupancy;
    logic [31:0] retire_count, drop_count;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    ent_t        mdl[$];
    ent_t        exp_q[$];
    logic [31:0] m_ret = '0;
    logic [31:0] m_drop = '0;
    logic        m_ovf = 1'b0;

    proc_trace_buf #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .trace_val(trace_val), .trace_addr(trace_addr), .trace_inst(trace_inst), .trace_data(trace_data),
        .out_val(out_val), .out_rdy(out_rdy),
        .out_addr(out_addr), .out_inst(out_inst), .out_data(out_data),
        .occupancy(occupancy), .retire_count(retire_count), .drop_count(drop_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp_v, $time);
        end
    endtask

    // Reference model: a plain queue of held entries plus counters
    initial forever begin
        ent_t e;
        @(posedge clk or negedge rst);
        if (!rst) begin
            mdl.delete();
            exp_q.delete();
            m_ret  = '0;
            m_drop = '0;
            m_ovf  = 1'b0;
        end else begin
            e.a = trace_addr;
            e.i = trace_inst;
            e.d = trace_data;
            if (mdl.size() != 0 && out_rdy) void'(mdl.pop_front());
            if (trace_val) begin
                m_ret++;
                if (mdl.size() < DEPTH) begin
                    mdl.push_back(e);
                    exp_q.push_back(e);
                end else begin
                    m_drop++;
                    m_ovf = 1'b1;
                end
            end
        end
    end

    // Monitor: samples just before each rising edge
    initial forever begin
        ent_t e;
        @(negedge clk);
        #4;
        if (rst) begin
            chk("occupancy", 32'(occupancy), 32'(mdl.size()));
            chk("out_val", 32'(out_val), 32'(mdl.size() != 0));
            chk("retire_count", retire_count, m_ret);
            chk("drop_count", drop_count, m_drop);
            chk("overflow", 32'(overflow), 32'(m_ovf));
            if (out_val && out_rdy) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_unexpected: got addr %h expected no entry", out_addr);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_addr", out_addr, e.a);
                    chk("sb_inst", out_inst, e.i);
                    chk("sb_data", out_data, e.d);
                end
            end
        end
    end

    task automatic drive(input logic tv, input logic [31:0] a, input logic [31:0] i,
                         input logic [31:0] d, input logic r);
        @(negedge clk);
        #1;
        trace_val  = tv;
        trace_addr = a;
        trace_inst = i;
        trace_data = d;
        out_rdy    = r;
    endtask

    task automatic sample();
        @(posedge clk);
        #1;
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        #1;
        trace_val = 1'b0;
        out_rdy   = 1'b0;
        rst       = 1'b0;
        #1;
        chk("rst_out_val", 32'(out_val), 0);
        chk("rst_occupancy", 32'(occupancy), 0);
        chk("rst_retire", retire_count, 0);
        chk("rst_drop", drop_count, 0);
        chk("rst_overflow", 32'(overflow), 0);
        #1;
        rst = 1'b1;
    endtask

    task automatic first_push();
        drive(1'b1, 32'h0, 32'h003100b3, 32'h5, 1'b0);
        sample();
        chk("t1_out_val", 32'(out_val), 1);
        chk("t1_out_addr", out_addr, 32'h0);
        chk("t1_out_inst", out_inst, 32'h003100b3);
        chk("t1_out_data", out_data, 32'h5);
        chk("t1_occupancy", 32'(occupancy), 1);
        chk("t1_retire", retire_count, 1);
    endtask

    initial begin
        int n;
        logic tv;
        #2;
        chk("init_out_val", 32'(out_val), 0);
        chk("init_occupancy", 32'(occupancy), 0);
        chk("init_retire", retire_count, 0);
        @(negedge clk);
        #1;
        rst = 1'b1;

        first_push();
        for (int i = 1; i < 5; i++) drive(1'b1, 32'(4 * i), $urandom, $urandom, 1'b0);
        drive(1'b0, 0, 0, 0, 1'b0);
        sample();
        chk("held5_occupancy", 32'(occupancy), 5);
        rst_pulse();
        first_push();

        rst_pulse();
        for (int i = 0; i < 10; i++) drive(1'b1, 32'(4 * i), $urandom, $urandom, 1'b0);
        drive(1'b0, 0, 0, 0, 1'b0);
        sample();
        chk("full_occupancy", 32'(occupancy), 8);
        chk("full_drop", drop_count, 2);
        chk("full_overflow", 32'(overflow), 1);
        chk("full_retire", retire_count, 10);
        chk("full_head", out_addr, 32'h0);
        drive(1'b1, 32'h200, $urandom, $urandom, 1'b1);
        sample();
        chk("pp_occupancy", 32'(occupancy), 8);
        chk("pp_drop", drop_count, 2);
        for (int k = 0; k < 8; k++) begin
            chk("drain_addr", out_addr, (k < 7) ? 32'(4 * (k + 1)) : 32'h200);
            drive(1'b0, 0, 0, 0, 1'b1);
            sample();
        end
        chk("drained_out_val", 32'(out_val), 0);
        chk("drained_overflow", 32'(overflow), 1);

        rst_pulse();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 32'h100 + 32'(4 * i), $urandom, $urandom, 1'b1);
            sample();
            chk("stream_addr", out_addr, 32'h100 + 32'(4 * i));
            chk("stream_occupancy", 32'(occupancy), 1);
        end
        drive(1'b0, 0, 0, 0, 1'b1);
        sample();
        chk("stream_drop", drop_count, 0);
        chk("stream_empty", 32'(occupancy), 0);

        rst_pulse();
        n = 0;
        while (n < 3 * DEPTH + 3) begin
            tv = 1'($urandom_range(0, 1));
            drive(tv, $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)));
            n += int'(tv);
        end
        for (int i = 0; i < 300; i++)
            drive(1'($urandom_range(0, 3) != 0), $urandom, $urandom, $urandom, 1'($urandom_range(0, 2) == 0));
        for (int i = 0; i < DEPTH + 2; i++) drive(1'b0, 0, 0, 0, 1'b1);
        sample();
        chk("final_empty", 32'(occupancy), 0);
        chk("sb_leftover", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
